// File: rtl/nibble_serial_adder.sv
// Adds WIDTH-bit operands one nibble per clock through an external 4-bit slice.
// Optional overflow flag output Ovf when OVERFLOW_FLAG_EN is defined.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S_out,
  output logic             Cout,
  output logic [3:0]       slice_A,
  output logic [3:0]       slice_B,
  output logic             slice_Cin,
  input  logic [3:0]       slice_S,
  input  logic             slice_Cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IW-1:0]    idx;

  // Present the current nibble pair to the slice only while running
  always_comb begin
    slice_A   = 4'd0;
    slice_B   = 4'd0;
    slice_Cin = 1'b0;
    if (state == RUN) begin
      slice_A   = a_r[4*idx +: 4];
      slice_B   = b_r[4*idx +: 4];
      slice_Cin = carry;
    end
  end

  // Sequencer: accept, step through nibbles chaining carry, flag done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S_out <= '0;
      Cout  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
`ifdef OVERFLOW_FLAG_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A_in;
            b_r   <= B_in;
            carry <= Cin;
            idx   <= '0;
            S_out <= '0;
            Cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            Ovf   <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          S_out[4*idx +: 4] <= slice_S;
          carry <= slice_Cout;
          if (idx == LAST) begin
            Cout  <= slice_Cout;
`ifdef OVERFLOW_FLAG_EN
            Ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &
                     (slice_S[3] != a_r[WIDTH-1]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with a behavioural 4-bit slice.
// Expected sums come from plain wide arithmetic on the operands.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         cout;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_s;
  logic         slice_cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  assign {slice_cout, slice_s} =
    5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A_in      (a_in),
    .B_in      (b_in),
    .Cin       (cin),
    .busy      (busy),
    .done      (done),
    .S_out     (s_out),
    .Cout      (cout),
    .slice_A   (slice_a),
    .slice_B   (slice_b),
    .slice_Cin (slice_cin),
    .slice_S   (slice_s),
    .slice_Cout(slice_cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .Ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W:0] res;
    logic       ov;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cin_trace;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_sum(input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic c);
    exp_t x;
    x.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    x.ov  = (a[W-1] == b[W-1]) && (x.res[W-1] != a[W-1]);
    q.push_back(x);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got 1 expected 0");
      end else begin
        e = q.pop_front();
        chk("sum", 32'(s_out), 32'(e.res[W-1:0]));
        chk("cout", 32'(cout), 32'(e.res[W]));
        chk("busy_with_done", 32'(busy), 32'd0);
`ifdef OVERFLOW_FLAG_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic wait_done(output int cyc, output int nb);
    cyc = 1;
    nb  = 0;
    cin_trace = '0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nb++;
      cin_trace[cyc] = slice_cin;
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", 32'(done === 1'b1), 32'd1);
  endtask

  task automatic op(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic c);
    int cyc;
    int nb;
    logic [W-1:0] held;
    expect_sum(a, b, c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nb);
    chk("latency", 32'(cyc), 32'(NIB + 1));
    chk("busy_cycles", 32'(nb), 32'(NIB));
    held = s_out;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold", 32'(s_out), 32'(held));
  endtask

  initial begin
    int cyc;
    int nb;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(s_out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(16'h1234, 16'h4321, 1'b0);
    chk("no_carry_trace", cin_trace, 32'd0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h0000, 16'h0000, 1'b1);
    chk("cin_first_only", cin_trace, 32'h2);

    // Start pulsed mid-run must be ignored
    expect_sum(16'h00F0, 16'h0010, 1'b0);
    @(negedge clk);
    a_in  = 16'h00F0;
    b_in  = 16'h0010;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in  = 16'hAAAA;
    b_in  = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nb);
    chk("ignored_start_latency", 32'(cyc), 32'(NIB - 1));
    @(negedge clk);
    @(negedge clk);
    chk("no_second_op", 32'(busy), 32'd0);
    op(16'hAAAA, 16'h5555, 1'b0);

    // Reset in the third busy cycle aborts the operation
    @(negedge clk);
    a_in  = 16'h8000;
    b_in  = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(s_out), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'h8000, 16'h8000, 1'b0);

`ifdef OVERFLOW_FLAG_EN
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h0001, 16'h0001, 1'b0);
`endif

    for (int i = 0; i < 25; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
    end

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
